// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//
// Read side of the synchronous FIFO. Pops words, absorbs the FIFO's one-cycle
// registered read latency and re-presents the words as a valid/ready stream
// that can move one word per clock.
//
// A 2-entry skid buffer (head/tail) holds captured words. A pop is only issued
// when the word it produces is guaranteed a slot, so the buffer cannot overflow.
//
// Ports
//   clk            : clock, all logic on posedge
//   rst_n          : synchronous reset, active-low
//   enable         : 1 = new pops permitted (in-flight/buffered words still drain)
//   fifo_empty     : FIFO empty flag
//   fifo_read_data : FIFO read data, valid the cycle after an accepted pop
//   fifo_pop       : pop request to the FIFO (combinational)
//   m_valid        : output word valid
//   m_data         : output word (buffer head)
//   m_ready        : consumer ready
//   beat_count     : completed output handshakes, wraps
//   busy           : a word is in flight or buffered
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_read_data,
    output logic             fifo_pop,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [CNT_W-1:0] beat_count,
    output logic             busy
);

    localparam logic [CNT_W-1:0] BEAT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_inflight;
    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [CNT_W-1:0] r_beat_count;

    logic             w_deq;
    logic [2:0]       w_occ;
    logic             w_room;

    assign w_deq  = m_valid & m_ready;
    // Words already committed to the buffer: stored plus the one in flight.
    assign w_occ  = {1'b0, r_count} + {2'b00, r_inflight};
    // A new pop lands next cycle; it needs a free slot, either now or one
    // freed by this edge's handshake.
    assign w_room = (w_occ <= 3'd1) | ((w_occ == 3'd2) & w_deq);

    assign fifo_pop   = rst_n & enable & ~fifo_empty & w_room;
    assign m_valid    = (r_count != 2'd0);
    assign m_data     = r_head;
    assign beat_count = r_beat_count;
    assign busy       = r_inflight | (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight   <= 1'b0;
            r_count      <= 2'd0;
            r_head       <= '0;
            r_tail       <= '0;
            r_beat_count <= '0;
        end else begin
            r_inflight <= fifo_pop;

            if (w_deq) begin
                r_beat_count <= r_beat_count + BEAT_ONE;
            end

            unique case ({w_deq, r_inflight})
                2'b11: begin
                    // Dequeue and capture together: tail shifts to head first,
                    // the new word goes in behind it. Count is unchanged.
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= fifo_read_data;
                    end else begin
                        r_head <= fifo_read_data;
                    end
                end
                2'b10: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd0) begin
                        r_head <= fifo_read_data;
                    end else begin
                        r_tail <= fifo_read_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Surrounds the reader with a behavioural FIFO (a queue with a registered
// read port that shows random junk when not popped). Every word written to
// the FIFO is logged as an expected output; a negedge monitor pops the log on
// each handshake and checks order, hold stability, beat counting, pop legality
// and the words-outstanding bound. Directed sequences plus a random phase.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             fifo_empty = 1'b1;
    logic [WIDTH-1:0] fifo_read_data = '0;
    logic             fifo_pop;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready = 1'b0;
    logic [CNT_W-1:0] beat_count;
    logic             busy;

    fifo_stream_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_read_data (fifo_read_data),
        .fifo_pop       (fifo_pop),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .beat_count     (beat_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural FIFO + expected-output log ----------------
    logic             push_req = 1'b0;
    logic [WIDTH-1:0] push_val = '0;
    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] exp_mem[0:4095];
    int               wr_ptr = 0;
    int               rd_ptr = 0;
    int               pops_total = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            fifo_q.delete();
            pops_total = 0;
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_pop && fifo_q.size() > 0) begin
                fifo_read_data <= fifo_q.pop_front();
                pops_total++;
            end else begin
                fifo_read_data <= WIDTH'($urandom);
            end
            if (push_req) begin
                fifo_q.push_back(push_val);
                exp_mem[wr_ptr[11:0]] = push_val;
                wr_ptr++;
            end
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic             mon_en = 1'b0;
    logic             hold_prev = 1'b0;
    logic [WIDTH-1:0] held = '0;
    int               exp_beats = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("beat_count", 32'(beat_count), 32'(exp_beats[CNT_W-1:0]));
            if (hold_prev) begin
                chk("hold_valid", 32'(m_valid), 32'h1);
                chk("hold_data", 32'(m_data), 32'(held));
            end
            if (fifo_pop) chk("pop_while_empty", 32'(fifo_empty), 32'h0);
            if (rst_n) chk("outstanding_le2", 32'((pops_total - exp_beats) <= 2), 32'h1);
            if (rst_n && m_valid && m_ready) begin
                if (rd_ptr == wr_ptr) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: got data 0x%0h, expected no word at %0t", m_data, $time);
                end else begin
                    chk("data_order", 32'(m_data), 32'(exp_mem[rd_ptr[11:0]]));
                    rd_ptr++;
                end
                exp_beats++;
            end
            hold_prev = rst_n && m_valid && !m_ready;
            held      = m_data;
            if (!rst_n) begin
                rd_ptr    = wr_ptr;
                exp_beats = 0;
                hold_prev = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        push_req = 1'b1;
        push_val = v;
        cyc();
        push_req = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        enable  = 1'b1;
        m_ready = 1'b1;
        while ((busy || fifo_q.size() != 0) && n < 300) begin
            cyc();
            n++;
        end
        chk(name, 32'(n < 300), 32'h1);
    endtask

    initial begin
        int p0;
        logic [CNT_W-1:0] b0;

        // reset
        rst_n = 1'b0;
        cyc(2);
        chk("rst_valid", 32'(m_valid), 32'h0);
        chk("rst_data", 32'(m_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_beats", 32'(beat_count), 32'h0);
        chk("rst_pop", 32'(fifo_pop), 32'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // full-throughput run of three words
        m_ready = 1'b1;
        push(8'h01); push(8'h02); push(8'h03);
        enable = 1'b1;
        #1;
        chk("t1_pop0", 32'(fifo_pop), 32'h1);
        cyc();
        chk("t1_pop1", 32'(fifo_pop), 32'h1);
        cyc();
        chk("t1_pop2", 32'(fifo_pop), 32'h1);
        chk("t1_valid", 32'(m_valid), 32'h1);
        chk("t1_data0", 32'(m_data), 32'h01);
        cyc();
        chk("t1_pop_empty", 32'(fifo_pop), 32'h0);
        chk("t1_data1", 32'(m_data), 32'h02);
        cyc();
        chk("t1_data2", 32'(m_data), 32'h03);
        cyc();
        chk("t1_busy", 32'(busy), 32'h0);
        chk("t1_beats", 32'(beat_count), 32'h3);

        // backpressure: only two pops until the consumer is ready
        enable = 1'b0; m_ready = 1'b0;
        push(8'h01); push(8'h02); push(8'h03);
        p0 = pops_total;
        enable = 1'b1;
        cyc(5);
        chk("t2_pops", 32'(pops_total - p0), 32'h2);
        chk("t2_valid", 32'(m_valid), 32'h1);
        chk("t2_data", 32'(m_data), 32'h01);
        chk("t2_nopop", 32'(fifo_pop), 32'h0);
        m_ready = 1'b1;
        #1;
        chk("t2_pop_on_hs", 32'(fifo_pop), 32'h1);
        drain("t2_drain");

        // eight words with toggling ready
        enable = 1'b0; m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            m_ready = (i % 2 == 0);
            cyc();
        end
        drain("t3_drain");
        chk("t3_all_out", 32'(rd_ptr), 32'(wr_ptr));

        // enable dropped right after the first pop
        enable = 1'b0; m_ready = 1'b1;
        b0 = beat_count;
        push(8'h04); push(8'h05);
        enable = 1'b1;
        cyc();
        enable = 1'b0;
        cyc(5);
        chk("t4_left_in_fifo", 32'(fifo_q.size()), 32'h1);
        chk("t4_beats1", 32'(beat_count), 32'(CNT_W'(b0 + 1)));
        drain("t4_drain");
        chk("t4_beats2", 32'(beat_count), 32'(CNT_W'(b0 + 2)));

        // reset with a full buffer
        enable = 1'b0; m_ready = 1'b0;
        push(8'hA1); push(8'hA2); push(8'hA3);
        enable = 1'b1;
        cyc(3);
        chk("t5_full_valid", 32'(m_valid), 32'h1);
        chk("t5_full_busy", 32'(busy), 32'h1);
        rst_n = 1'b0; m_ready = 1'b1;
        #1;
        chk("t5_pop_in_rst", 32'(fifo_pop), 32'h0);
        cyc();
        chk("t5_valid", 32'(m_valid), 32'h0);
        chk("t5_data", 32'(m_data), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_beats", 32'(beat_count), 32'h0);
        rst_n = 1'b1;
        cyc(2);

        // beat counter wrap (CNT_W = 4)
        enable = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 14; i++) push(8'(8'h30 + i));
        drain("t6_drain");
        chk("t6_beats14", 32'(beat_count), 32'hE);
        enable = 1'b0; m_ready = 1'b0;
        push(8'h50); push(8'h51);
        enable = 1'b1;
        cyc(4);
        m_ready = 1'b1;
        cyc();
        chk("t6_beatsF", 32'(beat_count), 32'hF);
        cyc();
        chk("t6_wrap0", 32'(beat_count), 32'h0);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            enable   = ($urandom_range(0, 3) != 0);
            m_ready  = ($urandom_range(0, 2) != 0);
            push_req = (fifo_q.size() < 12) && ($urandom_range(0, 1) == 1);
            push_val = WIDTH'($urandom);
            cyc();
        end
        push_req = 1'b0;
        drain("rand_drain");
        cyc(2);
        chk("rand_all_out", 32'(rd_ptr), 32'(wr_ptr));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
